seq_divider_32bit: RTL and testbench
====================================

Name: seq_divider_32bit

Overview:
Sequential radix-2 restoring integer divider. It is the inverse-operation companion to the booth radix-4 multiplier, and uses the same start/done handshake style. It serves the RISC-V PE M-extension DIV/DIVU/REM/REMU path: signed or unsigned 32-bit dividend/divisor in, 32-bit quotient and remainder out. It sits beside the multiplier in the execute stage.

Parameters:
WIDTH, 32, operand/result width in bits (only 32 is verified).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, synchronous, active-high
start  input  1  request pulse; sampled only in IDLE
is_signed  input  1  1 = signed two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU)
dividend  input  WIDTH  numerator, sampled with start
divisor  input  WIDTH  denominator, sampled with start
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse; quotient/remainder valid from this cycle onward

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; quotient=0, remainder=0, busy=0, done=0, iteration count=0. rst has priority over every other condition, including mid-operation; the in-flight result is discarded.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: with start=1 at edge E0, latch operands and is_signed, go to PREP, set busy=1.
- PREP (edge E1):
  - Compute absolute values when signed; record quotient sign (sign(dividend) XOR sign(divisor)) and remainder sign (sign(dividend)).
  - Special cases bypass CALC and go straight to DONE:
    - divisor==0: quotient=all ones, remainder=dividend (both modes).
    - Signed, dividend==0x80000000, divisor==0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Otherwise clear the partial remainder, load the quotient shift register, count=0, go to CALC.
- CALC, one iteration per clock, 32 iterations:
  - Shift {partial remainder, quotient} left by 1.
  - trial = partial remainder − |divisor|, computed at WIDTH+1 bits.
  - If trial is non-negative, partial remainder=trial and quotient LSB=1; else restore and LSB=0.
  - Leave for FIX after count reaches 31.
- FIX: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (signed mode only). Register results, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. quotient/remainder hold their value until the next accepted start's FIX or PREP writes them.
- Latency, counted from the start-sampling edge E0:
  - Normal: done high in the cycle after edge E0+35 (1 PREP + 32 CALC + 1 FIX + DONE entry).
  - Special case: done high after edge E0+2.
- start while busy (PREP/CALC/FIX/DONE): ignored. It is not queued, and operands are not resampled.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Sign rules follow RISC-V: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- Unsigned mode never negates, including for operands with bit 31 set.

Decomposition:
- Shared package div_pkg:
  - State encoding localparams (IDLE/PREP/CALC/FIX/DONE).
  - WIDTH default.
  - DIV_ZERO_QUOT constant (all ones).
  - SIGNED_MIN constant.
- One natural combinational sub-module, div_restoring_step: inputs {partial remainder, quotient, divisor magnitude}; outputs next partial remainder and next quotient. It is instantiated once in CALC.

Test Plan:
- Unsigned 100 / 7 (is_signed=0) -> quotient=14, remainder=2; done exactly 35 cycles after the start-sampling edge; busy high throughout.
- Signed −7 / 2 -> quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Signed 7 / −2 -> quotient=−3, remainder=1.
- Divide-by-zero 123 / 0, both modes -> quotient=0xFFFFFFFF, remainder=123, done after 2 cycles. Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. Unsigned 0x80000000 / 0xFFFFFFFF -> quotient=0, remainder=0x80000000.
- start re-pulsed with new operands during CALC -> ignored; the original result (1000 / 10 → 100, 0) is delivered unchanged.
- rst asserted during CALC at iteration 10 -> next cycle state=IDLE, quotient=remainder=0, busy=done=0. A fresh start afterwards (−5 / −9 signed) -> quotient=0, remainder=−5.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_PREP = S_PREP,
    ST_CALC = S_CALC,
    ST_FIX  = S_FIX,
    ST_DONE = S_DONE
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN    = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  // Two's-complement magnitude; only negates when operating signed.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                   input logic is_signed_op);
    return (is_signed_op && v[DIV_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor magnitude.
module div_restoring_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  // The shifted remainder can exceed WIDTH bits, so the trial is done at WIDTH+1.
  assign rem_shift = {rem_i, quo_i[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_i};

  always_comb begin
    rem_o = rem_shift[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_o    = trial[WIDTH-1:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider_32bit.sv
// Sequential restoring divider for RISC-V DIV/DIVU/REM/REMU; start/done handshake,
// one quotient bit per clock, with divide-by-zero and signed-overflow fast paths.
module seq_divider_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  div_state_t       state_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, dvs_mag_q;
  logic [WIDTH-1:0] rem_q, quo_q, rem_d, quo_d;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic [CW-1:0]    count_q;
  logic             signed_q, q_neg_q, r_neg_q, busy_q, done_q;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_mag_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      count_q     <= '0;
      signed_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            signed_q <= is_signed;
            busy_q   <= 1'b1;
            state_q  <= ST_PREP;
          end
        end
        ST_PREP: begin
          q_neg_q <= signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          r_neg_q <= signed_q & dvd_q[WIDTH-1];
          if (dvs_q == '0) begin
            quotient_q  <= DIV_ZERO_QUOT;
            remainder_q <= dvd_q;
            state_q     <= ST_DONE;
          end else if (signed_q && dvd_q == SIGNED_MIN && dvs_q == '1) begin
            quotient_q  <= SIGNED_MIN;
            remainder_q <= '0;
            state_q     <= ST_DONE;
          end else begin
            rem_q     <= '0;
            quo_q     <= abs_val(dvd_q, signed_q);
            dvs_mag_q <= abs_val(dvs_q, signed_q);
            count_q   <= '0;
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_ITER) state_q <= ST_FIX;
        end
        ST_FIX: begin
          quotient_q  <= q_neg_q ? -quo_q : quo_q;
          remainder_q <= r_neg_q ? -rem_q : rem_q;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed-vector bench for seq_divider_32bit: results, latency, busy/done handshake,
// start-while-busy and mid-operation reset.
module tb_seq_divider_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, remainder;
  logic        busy, done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  seq_divider_32bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Launch one operation; poke >= 0 re-pulses start with other operands after that cycle.
  task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                       input int elat, input int poke);
    int  n;
    bit  seen;
    int  busy_low;
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    n = 0; seen = 0; busy_low = 0;
    while (!seen && n < 100) begin
      if (n == poke) begin
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
      else if (!busy) busy_low++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_quo"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_busy_low"}, 32'(busy_low), 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_quo_hold"}, quotient, eq);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quo", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          35, -1);
    do_op("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  35, -1);
    do_op("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          35, -1);
    do_op("u123_0",   1'b0, 32'd123,        32'd0,          32'hFFFF_FFFF,  32'd123,        2,  -1);
    do_op("s123_0",   1'b1, 32'd123,        32'd0,          32'hFFFF_FFFF,  32'd123,        2,  -1);
    do_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          2,  -1);
    do_op("uFF_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          35, -1);
    do_op("u80_FF",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  35, -1);
    do_op("u1000_10_poke", 1'b0, 32'd1000,  32'd10,         32'd100,        32'd0,          35, 10);

    // Reset while CALC holds iteration count 10.
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_quo", quotient, 32'd0);
    chk("midrst_rem", remainder, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    do_op("s-5_-9", 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFB, 35, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
